// File: rtl/alu_req_arbiter_pkg.sv
// Shared opcode constants, FSM state type and opcode helper for the
// two-requester ALU arbiter.
package alu_req_arbiter_pkg;

    localparam logic [2:0] OP_MOV = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Anything above OR is reserved and answered with an error response.
    function automatic logic op_is_reserved(input logic [31:0] op);
        return op > 32'(OP_OR);
    endfunction

endpackage

// File: rtl/alu_req_arbiter_if.sv
// Bundle of requester, shared-ALU and response signals around the arbiter.
// The arbiter sits on the slave side; requesters, ALU and consumer on master.
interface alu_req_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 3
);
    logic              req0_valid;
    logic              req0_ready;
    logic [SEL_W-1:0]  req0_op;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic              req1_valid;
    logic              req1_ready;
    logic [SEL_W-1:0]  req1_op;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic [DATA_W-1:0] alu_data1;
    logic [DATA_W-1:0] alu_data2;
    logic [SEL_W-1:0]  alu_select;
    logic [DATA_W-1:0] alu_result;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic              resp_id;
    logic              resp_err;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  alu_result, resp_ready,
        output req0_ready, req1_ready,
        output alu_data1, alu_data2, alu_select,
        output resp_valid, resp_data, resp_id, resp_err
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output alu_result, resp_ready,
        input  req0_ready, req1_ready,
        input  alu_data1, alu_data2, alu_select,
        input  resp_valid, resp_data, resp_id, resp_err
    );
endinterface

// File: rtl/alu_req_arbiter_rr_arb2.sv
// Two-way round-robin decision: one-hot grant, favouring the requester
// that was not granted last when both are asking.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt
);
    always_comb begin
        gnt = req;
        if (&req) begin
            gnt = last_grant ? 2'b01 : 2'b10;
        end
    end
endmodule

// File: rtl/alu_req_arbiter.sv
// Arbitrates two requesters onto one external combinational ALU, one op in
// flight. Optional per-requester grant counters with ALU_ARB_STATS_EN.
//
// state   | meaning
// IDLE    | waiting; ready offered combinationally to the granted requester
// EXEC    | registered op/operands driven to the ALU; result captured at end
// RESP    | response held until resp_ready
module alu_req_arbiter
    import alu_req_arbiter_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 3
) (
    input  logic clk,
    input  logic reset,
    alu_req_arbiter_if.slave bus
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [7:0] grant_cnt0,
    output logic [7:0] grant_cnt1
`endif
);
    state_t            state_q, state_d;
    logic [SEL_W-1:0]  op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic              id_q, id_d;
    logic              last_grant_q, last_grant_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic              resp_err_q, resp_err_d;
    logic [1:0]        gnt;
    logic              accept;

    rr_arb2 u_arb (
        .req        ({bus.req1_valid, bus.req0_valid}),
        .last_grant (last_grant_q),
        .gnt        (gnt)
    );

    assign accept = (state_q == ST_IDLE) && (|gnt);

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        a_d            = a_q;
        b_d            = b_q;
        id_d           = id_q;
        last_grant_d   = last_grant_q;
        resp_data_d    = resp_data_q;
        resp_err_d     = resp_err_q;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.alu_data1  = '0;
        bus.alu_data2  = '0;
        bus.alu_select = '0;
        case (state_q)
            ST_IDLE: begin
                bus.req0_ready = gnt[0];
                bus.req1_ready = gnt[1];
                if (gnt[1]) begin
                    op_d         = bus.req1_op;
                    a_d          = bus.req1_a;
                    b_d          = bus.req1_b;
                    id_d         = 1'b1;
                    last_grant_d = 1'b1;
                    state_d      = ST_EXEC;
                end else if (gnt[0]) begin
                    op_d         = bus.req0_op;
                    a_d          = bus.req0_a;
                    b_d          = bus.req0_b;
                    id_d         = 1'b0;
                    last_grant_d = 1'b0;
                    state_d      = ST_EXEC;
                end
            end
            ST_EXEC: begin
                bus.alu_data1  = a_q;
                bus.alu_data2  = b_q;
                bus.alu_select = op_q;
                // Reserved ops still spend a cycle in EXEC but never expose the ALU answer.
                resp_err_d     = op_is_reserved(32'(op_q));
                resp_data_d    = resp_err_d ? '0 : bus.alu_result;
                state_d        = ST_RESP;
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign bus.resp_valid = (state_q == ST_RESP);
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_id    = id_q;
    assign bus.resp_err   = resp_err_q;

`ifdef ALU_ARB_STATS_EN
    logic [7:0] cnt0_q, cnt0_d;
    logic [7:0] cnt1_q, cnt1_d;

    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (accept && gnt[0] && (cnt0_q != 8'hFF)) cnt0_d = cnt0_q + 8'd1;
        if (accept && gnt[1] && (cnt1_q != 8'hFF)) cnt1_d = cnt1_q + 8'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt0_q <= 8'd0;
            cnt1_q <= 8'd0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
`endif
endmodule

// File: tb/tb_alu_req_arbiter.sv
// Scoreboard bench for alu_req_arbiter: directed scenarios then random traffic,
// checked against a transaction-level model of arbitration and ALU results.
module tb_alu_req_arbiter;
    typedef struct {
        logic       id;
        logic [7:0] data;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    alu_req_arbiter_if #(.DATA_W(8), .SEL_W(3)) ifc ();

`ifdef ALU_ARB_STATS_EN
    logic [7:0] gc0, gc1;
`endif

    alu_req_arbiter #(.DATA_W(8), .SEL_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
`ifdef ALU_ARB_STATS_EN
        ,
        .grant_cnt0 (gc0),
        .grant_cnt1 (gc1)
`endif
    );

    always #5 clk = ~clk;

    // External ALU stand-in; reserved selects return junk the arbiter must hide.
    always_comb begin
        case (ifc.alu_select)
            3'd0:    ifc.alu_result = ifc.alu_data2;
            3'd1:    ifc.alu_result = ifc.alu_data1 + ifc.alu_data2;
            3'd2:    ifc.alu_result = ifc.alu_data1 & ifc.alu_data2;
            3'd3:    ifc.alu_result = ifc.alu_data1 | ifc.alu_data2;
            default: ifc.alu_result = 8'hA5;
        endcase
    end

    // Reference model state
    exp_t q[$];
    logic rlog_id[$];
    int   rlog_data[$];
    bit   busy = 0;
    bit   last_g = 1;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   fl_op, fl_a, fl_b;
    bit   acc_seen[2];
    bit   rnd_rdy = 0;
    int   last_rdata = -1;
    int   last_rid = -1;
    int   last_rerr = -1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t ref_model(input logic id, input int op, input int a, input int b);
        exp_t e;
        e.id  = id;
        e.err = 1'b0;
        case (op)
            0:       e.data = 8'(b);
            1:       e.data = 8'((a + b) % 256);
            2:       e.data = 8'(a & b);
            3:       e.data = 8'(a | b);
            default: begin e.err = 1'b1; e.data = 8'h00; end
        endcase
        return e;
    endfunction

    function automatic logic [1:0] rr_ref(input logic [1:0] vld, input bit last);
        if (vld == 2'b11) return last ? 2'b01 : 2'b10;
        return vld;
    endfunction

    always @(negedge clk) begin
        logic [1:0] vld, obs_rdy, exp_rdy;
        bit   exp_rv;
        int   age;
        exp_t f, e;
        cyc++;
        if (!reset) begin
            age    = cyc - acc_cyc;
            exp_rv = busy && (age >= 2);
            chk("resp_valid", ifc.resp_valid, exp_rv);
            if (busy && age == 1) begin
                chk("exec_alu_data1", ifc.alu_data1, fl_a);
                chk("exec_alu_data2", ifc.alu_data2, fl_b);
                chk("exec_alu_select", ifc.alu_select, fl_op);
            end
            if (exp_rv && ifc.resp_valid) begin
                f = q[0];
                chk("resp_data", ifc.resp_data, f.data);
                chk("resp_id", ifc.resp_id, f.id);
                chk("resp_err", ifc.resp_err, f.err);
            end
            vld     = {ifc.req1_valid, ifc.req0_valid};
            obs_rdy = {ifc.req1_ready, ifc.req0_ready};
            exp_rdy = busy ? 2'b00 : rr_ref(vld, last_g);
            chk("req_ready", obs_rdy, exp_rdy);
            if (exp_rv && ifc.resp_valid && ifc.resp_ready) begin
                rlog_id.push_back(ifc.resp_id);
                rlog_data.push_back(int'(ifc.resp_data));
                last_rdata = int'(ifc.resp_data);
                last_rid   = int'(ifc.resp_id);
                last_rerr  = int'(ifc.resp_err);
                void'(q.pop_front());
                busy = 0;
            end
            if (!busy && exp_rdy != 2'b00) begin
                if (exp_rdy[1]) begin
                    fl_op = int'(ifc.req1_op); fl_a = int'(ifc.req1_a); fl_b = int'(ifc.req1_b);
                end else begin
                    fl_op = int'(ifc.req0_op); fl_a = int'(ifc.req0_a); fl_b = int'(ifc.req0_b);
                end
                e = ref_model(exp_rdy[1], fl_op, fl_a, fl_b);
                q.push_back(e);
                busy    = 1;
                acc_cyc = cyc;
                last_g  = exp_rdy[1];
                acc_seen[exp_rdy[1]] = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (acc_seen[0]) begin ifc.req0_valid = 1'b0; acc_seen[0] = 0; end
        if (acc_seen[1]) begin ifc.req1_valid = 1'b0; acc_seen[1] = 0; end
        if (rnd_rdy) ifc.resp_ready = ($urandom_range(0, 9) < 7);
    endtask

    task automatic set_req(input int n, input int op, input int a, input int b);
        if (n == 0) begin
            ifc.req0_valid = 1'b1; ifc.req0_op = 3'(op); ifc.req0_a = 8'(a); ifc.req0_b = 8'(b);
        end else begin
            ifc.req1_valid = 1'b1; ifc.req1_op = 3'(op); ifc.req1_a = 8'(a); ifc.req1_b = 8'(b);
        end
    endtask

    task automatic wait_idle(input string nm);
        int k = 0;
        while ((busy || ifc.req0_valid || ifc.req1_valid) && k < 400) begin
            tick();
            k++;
        end
        if (busy || ifc.req0_valid || ifc.req1_valid) begin
            total++; bad++;
            $display("FAIL %s_timeout: got=busy expected=idle within 400 cycles", nm);
        end
    endtask

    task automatic rst_assert();
        reset = 1'b1;
        q.delete();
        busy = 0;
        last_g = 1;
        acc_seen[0] = 0;
        acc_seen[1] = 0;
        @(negedge clk);
        chk("rst_resp_valid", ifc.resp_valid, 0);
        chk("rst_resp_data", ifc.resp_data, 0);
        chk("rst_resp_id", ifc.resp_id, 0);
        chk("rst_resp_err", ifc.resp_err, 0);
        chk("rst_alu_data1", ifc.alu_data1, 0);
        chk("rst_alu_data2", ifc.alu_data2, 0);
        chk("rst_alu_select", ifc.alu_select, 0);
`ifdef ALU_ARB_STATS_EN
        chk("rst_grant_cnt0", gc0, 0);
        chk("rst_grant_cnt1", gc1, 0);
`endif
    endtask

    task automatic rst_release();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        ifc.req0_valid = 0; ifc.req0_op = 0; ifc.req0_a = 0; ifc.req0_b = 0;
        ifc.req1_valid = 0; ifc.req1_op = 0; ifc.req1_a = 0; ifc.req1_b = 0;
        ifc.resp_ready = 1'b1;

        rst_assert();
        rst_release();
        tick();

        // MOV and ADD from requester 0
        set_req(0, 0, 5, 12);
        wait_idle("mov");
        chk("mov_data", last_rdata, 12);
        chk("mov_id", last_rid, 0);
        chk("mov_err", last_rerr, 0);
        set_req(0, 1, 5, 12);
        wait_idle("add");
        chk("add_data", last_rdata, 17);

        // Both valid straight out of reset: requester 0 first
        rst_assert();
        set_req(0, 1, 8'h18, 8'hFC);
        set_req(1, 1, 8'h03, 8'hFC);
        rlog_id.delete();
        rlog_data.delete();
        rst_release();
        wait_idle("both");
        chk("both_count", rlog_id.size(), 2);
        if (rlog_id.size() == 2) begin
            chk("both_first_id", rlog_id[0], 0);
            chk("both_first_data", rlog_data[0], 8'h14);
            chk("both_second_id", rlog_id[1], 1);
            chk("both_second_data", rlog_data[1], 8'hFF);
        end

        // Back-pressure: response held while req1 waits
        ifc.resp_ready = 1'b0;
        set_req(0, 1, 1, 2);
        k = 0;
        while (!ifc.resp_valid && k < 20) begin tick(); k++; end
        chk("bp_resp_seen", ifc.resp_valid, 1);
        set_req(1, 2, 8'hF0, 8'h3C);
        repeat (5) tick();
        chk("bp_req1_ready_held", ifc.req1_ready, 0);
        chk("bp_resp_valid_held", ifc.resp_valid, 1);
        ifc.resp_ready = 1'b1;
        tick();
        chk("bp_retired", ifc.resp_valid, 0);
        chk("bp_retired_data", last_rdata, 3);
        wait_idle("bp");
        chk("bp_req1_data", last_rdata, 8'h30);

        // Reserved opcode then OR
        set_req(1, 5, 8'h77, 8'h11);
        wait_idle("rsvd");
        chk("rsvd_err", last_rerr, 1);
        chk("rsvd_data", last_rdata, 0);
        set_req(1, 3, 5, 12);
        wait_idle("or");
        chk("or_data", last_rdata, 8'h0D);
        chk("or_err", last_rerr, 0);

        // Reset while the op is in EXEC discards it
        set_req(0, 1, 8'hF9, 8'h04);
        k = 0;
        while (ifc.req0_valid && k < 20) begin tick(); k++; end
        rst_assert();
        rst_release();
        last_rdata = -1;
        repeat (4) tick();
        chk("rst_exec_no_resp", last_rdata, -1);
        set_req(0, 1, 8'hF9, 8'h04);
        wait_idle("resubmit");
        chk("resubmit_data", last_rdata, 8'hFD);
`ifdef ALU_ARB_STATS_EN
        chk("resubmit_grant_cnt0", gc0, 1);
        chk("resubmit_grant_cnt1", gc1, 0);
`endif

        // Random traffic with random back-pressure
        rnd_rdy = 1;
        for (int i = 0; i < 1500; i++) begin
            tick();
            if (!ifc.req0_valid && $urandom_range(0, 3) == 0)
                set_req(0, $urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 255));
            if (!ifc.req1_valid && $urandom_range(0, 3) == 0)
                set_req(1, $urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 255));
        end
        wait_idle("random");
        rnd_rdy = 0;
        ifc.resp_ready = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
